// File: rtl/spi_pkg.sv
// Shared types and defaults for the two-port SPI master sequencer.
package spi_pkg;

  localparam int unsigned FRAME_W_DEF = 10;
  localparam int unsigned DATA_W_DEF  = 8;
  localparam int unsigned CNT_W       = 4;

  typedef enum logic [1:0] {
    CMD_WR_ADDR = 2'b00,
    CMD_WR_DATA = 2'b01,
    CMD_RD_ADDR = 2'b10,
    CMD_RD_DATA = 2'b11
  } cmd_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEL,
    ST_CMD,
    ST_SHIFT,
    ST_WAIT,
    ST_RECV,
    ST_GAP
  } state_e;

endpackage

// File: rtl/spi_master_arb_rr_arb2.sv
// Two-way round-robin arbiter with last-grant pointer.
// Optional read-address lock when SPI_ARB_LOCK_EN is defined.
module rr_arb2
  import spi_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       take,
  input  logic       lock_set,
  input  logic       lock_clr,
  output logic [1:0] grant_c
);

  logic       last;
  logic [1:0] req_eff;

`ifdef SPI_ARB_LOCK_EN
  logic locked;
  logic owner;

  // While locked only the owner may be granted.
  always_comb begin
    req_eff = req;
    if (locked) req_eff = owner ? (req & 2'b10) : (req & 2'b01);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      locked <= 1'b0;
      owner  <= 1'b0;
    end else if (lock_clr) begin
      locked <= 1'b0;
    end else if (take && lock_set && |grant_c) begin
      locked <= 1'b1;
      owner  <= grant_c[1];
    end
  end
`else
  logic unused_lock;
  assign unused_lock = lock_set ^ lock_clr;
  assign req_eff     = req;
`endif

  always_comb begin
    grant_c = 2'b00;
    case (req_eff)
      2'b01:   grant_c = 2'b01;
      2'b10:   grant_c = 2'b10;
      2'b11:   grant_c = last ? 2'b01 : 2'b10;
      default: grant_c = 2'b00;
    endcase
  end

  // last=1 after reset so requester 0 wins the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 last <= 1'b1;
    else if (take && |grant_c)  last <= grant_c[1];
  end

endmodule

// File: rtl/spi_master_arb.sv
// SPI master sequencer sharing one slave link between two requesters.
// Define SPI_ARB_LOCK_EN to keep read-address/read-data pairs atomic per requester.
module spi_master_arb
  import spi_pkg::*;
#(
  parameter int unsigned FRAME_W  = FRAME_W_DEF,
  parameter int unsigned DATA_W   = DATA_W_DEF,
  parameter int unsigned MISO_DLY = 2,
  parameter int unsigned GAP      = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [1:0]         req,
  input  logic [FRAME_W-1:0] frame0,
  input  logic [FRAME_W-1:0] frame1,
  output logic [1:0]         gnt,
  output logic               busy,
  output logic               done,
  output logic               done_id,
  output logic               rd_valid,
  output logic [DATA_W-1:0]  rd_data,
  output logic               SS_n,
  output logic               MOSI,
  input  logic               MISO
);

  state_e             state;
  logic [CNT_W-1:0]   cnt;
  logic               id;
  logic [FRAME_W-1:0] frm;
  logic [FRAME_W-1:0] sr;
  logic [DATA_W-2:0]  rx;

  logic [1:0]         grant_c;
  logic               take_c;
  logic [FRAME_W-1:0] sel_frame_c;
  logic               lock_set_c;
  logic               lock_clr_c;
  logic               is_rd_data_c;

  assign take_c       = (state == ST_IDLE) && |grant_c;
  assign sel_frame_c  = grant_c[1] ? frame1 : frame0;
  assign lock_set_c   = cmd_e'(sel_frame_c[FRAME_W-1 -: 2]) == CMD_RD_ADDR;
  assign lock_clr_c   = (state == ST_RECV) && (cnt == CNT_W'(DATA_W - 1));
  assign is_rd_data_c = cmd_e'(frm[FRAME_W-1 -: 2]) == CMD_RD_DATA;

  rr_arb2 u_arb (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .take     (take_c),
    .lock_set (lock_set_c),
    .lock_clr (lock_clr_c),
    .grant_c  (grant_c)
  );

  // Frame sequencer; every output is registered on the transition into its state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      id       <= 1'b0;
      frm      <= '0;
      sr       <= '0;
      rx       <= '0;
      gnt      <= 2'b00;
      busy     <= 1'b0;
      done     <= 1'b0;
      done_id  <= 1'b0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
      SS_n     <= 1'b1;
      MOSI     <= 1'b0;
    end else begin
      gnt      <= 2'b00;
      done     <= 1'b0;
      rd_valid <= 1'b0;
      cnt      <= cnt + CNT_W'(1);
      case (state)
        ST_IDLE: begin
          cnt <= '0;
          if (take_c) begin
            state <= ST_SEL;
            gnt   <= grant_c;
            id    <= grant_c[1];
            frm   <= sel_frame_c;
            SS_n  <= 1'b0;
            MOSI  <= 1'b0;
            busy  <= 1'b1;
          end
        end
        ST_SEL: begin
          state <= ST_CMD;
          cnt   <= '0;
          MOSI  <= frm[FRAME_W-1];
        end
        ST_CMD: begin
          state <= ST_SHIFT;
          cnt   <= '0;
          MOSI  <= frm[FRAME_W-1];
          sr    <= {frm[FRAME_W-2:0], 1'b0};
        end
        ST_SHIFT: begin
          if (cnt == CNT_W'(FRAME_W - 1)) begin
            cnt  <= '0;
            MOSI <= 1'b0;
            if (is_rd_data_c) begin
              state <= ST_WAIT;
            end else begin
              state   <= ST_GAP;
              SS_n    <= 1'b1;
              done    <= 1'b1;
              done_id <= id;
            end
          end else begin
            MOSI <= sr[FRAME_W-1];
            sr   <= {sr[FRAME_W-2:0], 1'b0};
          end
        end
        ST_WAIT: begin
          if (cnt == CNT_W'(MISO_DLY - 1)) begin
            state <= ST_RECV;
            cnt   <= '0;
          end
        end
        ST_RECV: begin
          rx <= {rx[DATA_W-3:0], MISO};
          if (cnt == CNT_W'(DATA_W - 1)) begin
            state    <= ST_GAP;
            cnt      <= '0;
            SS_n     <= 1'b1;
            done     <= 1'b1;
            done_id  <= id;
            rd_valid <= 1'b1;
            rd_data  <= {rx, MISO};
          end
        end
        ST_GAP: begin
          if (cnt == CNT_W'(GAP - 1)) begin
            state <= ST_IDLE;
            cnt   <= '0;
            busy  <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master_arb.sv
// Directed bench for spi_master_arb: single frames, contention, lock ordering, mid-frame reset.
module tb_spi_master_arb;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] req;
  logic [9:0] frame0, frame1;
  logic [1:0] gnt;
  logic       busy, done, done_id, rd_valid;
  logic [7:0] rd_data;
  logic       SS_n, MOSI, MISO;

  int total = 0;
  int bad   = 0;
  logic [7:0] last_rd;

  typedef struct {
    logic        id;
    logic [9:0]  frame;
    logic [7:0]  miso;
    logic [11:0] exp_mosi;
    int          exp_low;
    logic        exp_rdv;
  } vec_t;

  vec_t vecs[6];

  always #5 clk = ~clk;

  spi_master_arb dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .frame0   (frame0),
    .frame1   (frame1),
    .gnt      (gnt),
    .busy     (busy),
    .done     (done),
    .done_id  (done_id),
    .rd_valid (rd_valid),
    .rd_data  (rd_data),
    .SS_n     (SS_n),
    .MOSI     (MOSI),
    .MISO     (MISO)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic wait_gnt(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (gnt == 2'b00 && n < 40);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((busy !== 1'b0 || SS_n !== 1'b1) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("idle_reached", 32'(busy), 32'(0));
  endtask

  // Runs one frame from an idle block; the bench plays the slave on MISO.
  task automatic run_vec(input vec_t v);
    int          k;
    int          n;
    logic [11:0] mosi_seq;
    logic [7:0]  sh;
    logic [7:0]  exp_rd;
    if (v.id) frame1 = v.frame;
    else      frame0 = v.frame;
    req[v.id] = 1'b1;
    wait_gnt(n);
    check("gnt_latency", 32'(n), 32'(1));
    check("gnt", 32'(gnt), v.id ? 32'(2) : 32'(1));
    req      = 2'b00;
    k        = 0;
    mosi_seq = '0;
    sh       = v.miso;
    while (SS_n == 1'b0 && k < 40) begin
      if (k < 12) mosi_seq = {mosi_seq[10:0], MOSI};
      if (k >= 14 && k < 22) begin
        MISO = sh[7];
        sh   = {sh[6:0], 1'b0};
      end else begin
        MISO = 1'b0;
      end
      k++;
      @(negedge clk);
    end
    MISO = 1'b0;
    exp_rd = v.exp_rdv ? v.miso : last_rd;
    check("ss_low_cycles", 32'(k), 32'(v.exp_low));
    check("mosi_seq", 32'(mosi_seq), 32'(v.exp_mosi));
    check("done", 32'(done), 32'(1));
    check("done_id", 32'(done_id), 32'(v.id));
    check("rd_valid", 32'(rd_valid), 32'(v.exp_rdv));
    check("rd_data", 32'(rd_data), 32'(exp_rd));
    check("busy_in_gap", 32'(busy), 32'(1));
    last_rd = exp_rd;
    @(negedge clk);
    check("after_gap", 32'({done, rd_valid, busy, SS_n}), 32'(4'b0001));
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          n;
    int          cyc;
    int          ngr;
    int          rise_cyc;
    logic        prev_ss;
    logic [5:0]  gseq;

    vecs[0] = '{1'b0, 10'h0A5, 8'h00, 12'h0A5, 12, 1'b0};
    vecs[1] = '{1'b1, 10'h300, 8'hC3, 12'h700, 22, 1'b1};
    vecs[2] = '{1'b0, 10'h2F0, 8'h00, 12'h6F0, 12, 1'b0};
    vecs[3] = '{1'b0, 10'h3A5, 8'h5A, 12'h7A5, 22, 1'b1};
    vecs[4] = '{1'b1, 10'h1FF, 8'h00, 12'h1FF, 12, 1'b0};
    vecs[5] = '{1'b1, 10'h355, 8'h01, 12'h755, 22, 1'b1};

    rst_n   = 1'b0;
    req     = 2'b00;
    frame0  = '0;
    frame1  = '0;
    MISO    = 1'b0;
    last_rd = 8'h00;
    repeat (2) @(negedge clk);
    check("reset_outputs",
          32'({SS_n, MOSI, gnt, busy, done, done_id, rd_valid, rd_data}), 32'(16'h8000));
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 6; i++) run_vec(vecs[i]);

    // Contention: both requesters held, grants must alternate with a 2-cycle gap.
    frame0   = 10'h0A5;
    frame1   = 10'h1FF;
    req      = 2'b11;
    cyc      = 0;
    ngr      = 0;
    rise_cyc = 0;
    prev_ss  = SS_n;
    gseq     = '0;
    while (ngr < 3 && cyc < 300) begin
      @(negedge clk);
      cyc++;
      if (prev_ss == 1'b0 && SS_n == 1'b1) rise_cyc = cyc;
      prev_ss = SS_n;
      if (gnt != 2'b00) begin
        gseq = {gseq[3:0], gnt};
        if (ngr > 0) check("rr_rise_to_gnt", 32'(cyc - rise_cyc), 32'(2));
        ngr++;
      end
    end
    req = 2'b00;
    check("rr_grant_seq", 32'(gseq), 32'(6'b01_10_01));
    wait_idle();

    // Read-address then read-data from requester 1 while requester 0 also asks.
    frame1 = 10'h2F0;
    req    = 2'b10;
    wait_gnt(n);
    check("lock_first_gnt", 32'(gnt), 32'(2));
    frame1 = 10'h300;
    frame0 = 10'h0A5;
    req    = 2'b11;
    gseq   = '0;
    ngr    = 0;
    cyc    = 0;
    while (ngr < 2 && cyc < 300) begin
      @(negedge clk);
      cyc++;
      if (gnt != 2'b00) begin
        gseq = {gseq[3:0], gnt};
        ngr++;
      end
    end
    req = 2'b00;
`ifdef SPI_ARB_LOCK_EN
    check("lock_grant_seq", 32'(gseq[3:0]), 32'(4'b10_01));
`else
    check("nolock_grant_seq", 32'(gseq[3:0]), 32'(4'b01_10));
`endif
    wait_idle();

    // Mid-frame reset: SS_n must rise without a clock edge and no done may follow.
    frame0 = 10'h0A5;
    req    = 2'b01;
    wait_gnt(n);
    req = 2'b00;
    repeat (5) @(negedge clk);
    check("pre_reset_ss", 32'(SS_n), 32'(0));
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_ss", 32'(SS_n), 32'(1));
    check("async_reset_outs", 32'({gnt, busy, done, rd_valid}), 32'(0));
    repeat (2) begin
      @(negedge clk);
      check("no_done_in_reset", 32'(done), 32'(0));
    end
    rst_n  = 1'b1;
    frame1 = 10'h1FF;
    req    = 2'b11;
    wait_gnt(n);
    check("post_reset_gnt", 32'(gnt), 32'(1));
    req = 2'b00;
    wait_idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
